// File: rtl/calc_ctrl_if.sv
// Keypad-to-calculator bundle: key strobe/code in, display value and status out.
interface calc_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] disp_data;
    logic        disp_err;
    logic        busy;

    modport master (
        output key_valid,
        output key_code,
        input  disp_data,
        input  disp_err,
        input  busy
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output disp_data,
        output disp_err,
        output busy
    );
endinterface

// File: rtl/calc_ctrl.sv
// Four-function keypad calculator controller with a multi-cycle restoring divider.
module calc_ctrl #(
    parameter int DIGITS     = 3,
    parameter int DIV_CYCLES = 16
) (
    input logic        clk,
    input logic        rst_n,
    calc_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_OPA    = 3'd0,
        ST_OPB    = 3'd1,
        ST_DIV    = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    localparam int unsigned KEEP_MOD = pow10(DIGITS - 1);

    // Drops the oldest digit once the operand already holds DIGITS digits.
    function automatic logic [15:0] shift_digit(input logic [15:0] v, input logic [3:0] d);
        logic [31:0] t;
        t = ((32'(v) % KEEP_MOD) * 32'd10) + 32'(d);
        return t[15:0];
    endfunction

    function automatic op_t op_of(input logic [3:0] code);
        op_t o;
        case (code)
            4'hA:    o = OP_ADD;
            4'hB:    o = OP_SUB;
            4'hC:    o = OP_MUL;
            4'hD:    o = OP_DIV;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

    state_t        state_r;
    op_t           op_r;
    logic [15:0]   opa_r;
    logic [15:0]   opb_r;
    logic [15:0]   result_r;
    logic [15:0]   quo_r;
    logic [15:0]   rem_r;
    logic [CW-1:0] cnt_r;
    logic [15:0]   disp_r;
    logic          err_r;
    logic          busy_r;

    logic          is_digit_s;
    logic          is_op_s;
    logic          is_eq_s;
    logic          is_clr_s;
    logic [16:0]   sum_s;
    logic [31:0]   prod_s;
    logic [16:0]   div_shift_s;
    logic [16:0]   div_trial_s;
    logic          div_fit_s;
    logic [15:0]   rem_next_s;
    logic [15:0]   quo_next_s;

    // Key decode, single-cycle arithmetic and one restoring-division step.
    always_comb begin
        is_digit_s  = bus.key_valid && (bus.key_code <= 4'd9);
        is_op_s     = bus.key_valid && (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);
        is_eq_s     = bus.key_valid && (bus.key_code == 4'hE);
        is_clr_s    = bus.key_valid && (bus.key_code == 4'hF);
        sum_s       = {1'b0, opa_r} + {1'b0, opb_r};
        prod_s      = 32'(opa_r) * 32'(opb_r);
        div_shift_s = {rem_r, quo_r[15]};
        div_trial_s = div_shift_s - {1'b0, opb_r};
        // Bit 16 set means the trial subtraction went negative (remainder restored).
        div_fit_s   = ~div_trial_s[16];
        rem_next_s  = div_fit_s ? div_trial_s[15:0] : div_shift_s[15:0];
        quo_next_s  = {quo_r[14:0], div_fit_s};
    end

    // Calculator FSM; display and status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n || is_clr_s) begin
            state_r  <= ST_OPA;
            op_r     <= OP_ADD;
            opa_r    <= 16'd0;
            opb_r    <= 16'd0;
            result_r <= 16'd0;
            quo_r    <= 16'd0;
            rem_r    <= 16'd0;
            cnt_r    <= '0;
            disp_r   <= 16'd0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_OPA: begin
                    if (is_digit_s) begin
                        opa_r  <= shift_digit(opa_r, bus.key_code);
                        disp_r <= shift_digit(opa_r, bus.key_code);
                    end else if (is_op_s) begin
                        op_r    <= op_of(bus.key_code);
                        opb_r   <= 16'd0;
                        disp_r  <= 16'd0;
                        state_r <= ST_OPB;
                    end else if (is_eq_s) begin
                        result_r <= opa_r;
                        disp_r   <= opa_r;
                        state_r  <= ST_RESULT;
                    end
                end
                ST_OPB: begin
                    if (is_digit_s) begin
                        opb_r  <= shift_digit(opb_r, bus.key_code);
                        disp_r <= shift_digit(opb_r, bus.key_code);
                    end else if (is_op_s) begin
                        op_r <= op_of(bus.key_code);
                    end else if (is_eq_s) begin
                        case (op_r)
                            OP_ADD: begin
                                if (sum_s[16]) begin
                                    state_r <= ST_ERR;
                                    disp_r  <= 16'd0;
                                    err_r   <= 1'b1;
                                end else begin
                                    result_r <= sum_s[15:0];
                                    disp_r   <= sum_s[15:0];
                                    state_r  <= ST_RESULT;
                                end
                            end
                            OP_SUB: begin
                                if (opb_r > opa_r) begin
                                    state_r <= ST_ERR;
                                    disp_r  <= 16'd0;
                                    err_r   <= 1'b1;
                                end else begin
                                    result_r <= opa_r - opb_r;
                                    disp_r   <= opa_r - opb_r;
                                    state_r  <= ST_RESULT;
                                end
                            end
                            OP_MUL: begin
                                if (prod_s[31:16] != 16'd0) begin
                                    state_r <= ST_ERR;
                                    disp_r  <= 16'd0;
                                    err_r   <= 1'b1;
                                end else begin
                                    result_r <= prod_s[15:0];
                                    disp_r   <= prod_s[15:0];
                                    state_r  <= ST_RESULT;
                                end
                            end
                            default: begin
                                if (opb_r == 16'd0) begin
                                    state_r <= ST_ERR;
                                    disp_r  <= 16'd0;
                                    err_r   <= 1'b1;
                                end else begin
                                    quo_r   <= opa_r;
                                    rem_r   <= 16'd0;
                                    cnt_r   <= '0;
                                    busy_r  <= 1'b1;
                                    state_r <= ST_DIV;
                                end
                            end
                        endcase
                    end
                end
                ST_DIV: begin
                    quo_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(DIV_CYCLES - 1)) begin
                        result_r <= quo_next_s;
                        disp_r   <= quo_next_s;
                        busy_r   <= 1'b0;
                        state_r  <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (is_digit_s) begin
                        opa_r   <= 16'(bus.key_code);
                        opb_r   <= 16'd0;
                        disp_r  <= 16'(bus.key_code);
                        state_r <= ST_OPA;
                    end else if (is_op_s) begin
                        opa_r   <= result_r;
                        op_r    <= op_of(bus.key_code);
                        opb_r   <= 16'd0;
                        disp_r  <= 16'd0;
                        state_r <= ST_OPB;
                    end
                end
                ST_ERR: begin
                    disp_r <= 16'd0;
                    err_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_OPA;
                    disp_r  <= 16'd0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_data = disp_r;
    assign bus.disp_err  = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: keyed sequences with hand-computed display/status values.
module tb_calc_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   nbusy;

    calc_ctrl_if bus ();

    calc_ctrl #(.DIGITS(3), .DIV_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] d, input logic e, input logic b);
        chk({tag, "_data"}, bus.disp_data, d);
        chk({tag, "_err"},  16'(bus.disp_err), 16'(e));
        chk({tag, "_busy"}, 16'(bus.busy), 16'(b));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        repeat (2) @(negedge clk);
        chk_state("reset", 16'd0, 1'b0, 1'b0);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst_n         = 1'b1;
        @(negedge clk);
        chk_state("post_reset", 16'd0, 1'b0, 1'b0);

        press(4'h1); press(4'h2); press(4'h3);
        chk("add_opa", bus.disp_data, 16'd123);
        press(4'hA);
        chk("add_opb_clr", bus.disp_data, 16'd0);
        press(4'h4); press(4'h5);
        chk("add_opb", bus.disp_data, 16'd45);
        press(4'hE);
        chk_state("add_res", 16'd168, 1'b0, 1'b0);

        press(4'hF);
        press(4'h7); chk("dig1", bus.disp_data, 16'd7);
        press(4'h8); chk("dig2", bus.disp_data, 16'd78);
        press(4'h9); chk("dig3", bus.disp_data, 16'd789);
        press(4'h1); chk("dig4_drop", bus.disp_data, 16'd891);

        press(4'hF);
        press(4'h9); press(4'h9); press(4'h9); press(4'hC);
        press(4'h9); press(4'h9); press(4'h9); press(4'hE);
        chk_state("mul_ovf", 16'd0, 1'b1, 1'b0);
        press(4'h5);
        chk_state("err_ignore", 16'd0, 1'b1, 1'b0);
        press(4'hF);
        chk_state("err_clear", 16'd0, 1'b0, 1'b0);
        press(4'h2);
        chk("after_clear", bus.disp_data, 16'd2);

        press(4'hF);
        press(4'h1); press(4'h0); press(4'h0); press(4'hD); press(4'h7); press(4'hE);
        chk("div_hold_disp", bus.disp_data, 16'd7);
        nbusy = 0;
        while (bus.busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
        chk("div_busy_cycles", 16'(nbusy), 16'd16);
        chk_state("div_res", 16'd14, 1'b0, 1'b0);
        press(4'hB); press(4'h4); press(4'hE);
        chk("chain_sub", bus.disp_data, 16'd10);

        press(4'hF);
        press(4'h8); press(4'hD); press(4'h0);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hE;
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk_state("div_zero", 16'd0, 1'b1, 1'b0);
        press(4'hF);
        press(4'h5); press(4'hB); press(4'h9); press(4'hE);
        chk_state("sub_neg", 16'd0, 1'b1, 1'b0);

        press(4'hF);
        press(4'h9); press(4'h9); press(4'h9); press(4'hC); press(4'h6); press(4'h5); press(4'hE);
        chk_state("mul_max", 16'd64935, 1'b0, 1'b0);
        press(4'hA); press(4'h9); press(4'h9); press(4'h9); press(4'hE);
        chk_state("add_ovf", 16'd0, 1'b1, 1'b0);

        press(4'hF);
        press(4'h8); press(4'hA); press(4'h3); press(4'hC);
        chk("op_replace_disp", bus.disp_data, 16'd3);
        press(4'hE);
        chk("op_replace_res", bus.disp_data, 16'd24);
        press(4'hE);
        chk("eq_in_result", bus.disp_data, 16'd24);

        press(4'hF);
        press(4'h1); press(4'h0); press(4'h0); press(4'hD); press(4'h7); press(4'hE);
        repeat (4) @(negedge clk);
        chk("div_5th_busy", 16'(bus.busy), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_state("div_reset", 16'd0, 1'b0, 1'b0);
        press(4'h3);
        chk("resume_digit", bus.disp_data, 16'd3);
        press(4'hE);
        chk_state("resume_eq", 16'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter DIGITS, default 3: maximum decimal digits per keyed operand.
REQ-002 Parameter DIV_CYCLES, default 16: divider iteration count, equal to the operand width.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port key_valid, input, 1: one-cycle strobe; key_code is valid in this cycle.
REQ-006 Port key_code, input, 4: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
REQ-007 Port disp_data, output, 16: unsigned binary value for the display decoder.
REQ-008 Port disp_err, output, 1: error indication.
REQ-009 Port busy, output, 1: divider running; keys other than F are ignored.

Function
REQ-010 The block SHALL be an FSM with states OPA, OPB, DIV, RESULT, ERR.
REQ-011 Registers SHALL be: opa[15:0], opb[15:0], op[1:0], result[15:0], and the divider quotient/remainder working registers.
REQ-012 A key SHALL be accepted only in a cycle where key_valid=1; effects SHALL be visible the next cycle.
REQ-013 Digit d in OPA SHALL set opa = (opa mod 10^(DIGITS-1))*10 + d, so a 4th digit drops the oldest digit; OPB SHALL update opb the same way.
REQ-014 Operator key (A-D) in OPA SHALL latch op, clear opb, and enter OPB.
REQ-015 Operator key in OPB SHALL replace op and leave opb unchanged.
REQ-016 Operator key in RESULT SHALL set opa=result, latch op, clear opb, and enter OPB (chaining).
REQ-017 E in OPA SHALL set result=opa and enter RESULT.
REQ-018 E in OPB with op add/sub/mul SHALL compute in the same cycle and enter RESULT, or ERR on error.
REQ-019 Arithmetic errors: add >65535, sub with opb>opa, mul product >65535, div with opb=0.
REQ-020 E in OPB with op div and opb≠0 SHALL enter DIV.
REQ-021 DIV SHALL run restoring division for exactly DIV_CYCLES cycles, holding busy=1 in each, then enter RESULT with result=floor(opa/opb).
REQ-022 Digit in RESULT SHALL clear opa and opb, set opa=d, and enter OPA.
REQ-023 E in RESULT SHALL be ignored.
REQ-024 F in any state, including DIV (abort), SHALL clear all registers and enter OPA.
REQ-025 In ERR, all keys except F SHALL be ignored.
REQ-026 disp_data SHALL show opa in OPA, opb in OPB, result in RESULT, 0 in ERR, and the last value shown in DIV.
REQ-027 disp_err SHALL be 1 only in ERR.
REQ-028 busy SHALL be 1 only in DIV.
REQ-029 Codes 0-9 SHALL be digits; no code is undefined.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force state OPA and opa=opb=result=op=0, and clear the divider.
REQ-031 While in reset, outputs SHALL be disp_data=0, disp_err=0, busy=0.
REQ-032 Reset SHALL take priority over key_valid, including during DIV.
REQ-033 Operation SHALL resume on the first edge with rst_n=1.

Verification
REQ-034 Keys 1,2,3,A,4,5,E -> disp_data 123, then 45, then 168; disp_err=0.
REQ-035 Keys 7,8,9,1 -> disp_data 7, 78, 789, 891.
REQ-036 Keys 9,9,9,C,9,9,9,E -> ERR, disp_err=1, disp_data=0; then key 5 ignored; then F -> OPA, disp_data=0.
REQ-037 Keys 1,0,0,D,7,E -> busy=1 for exactly 16 cycles, then disp_data=14, busy=0; then keys B,4,E -> 10.
REQ-038 Keys 8,D,0,E -> ERR with no busy cycle; keys 5,B,9,E -> ERR.
REQ-039 rst_n=0 for one cycle during the 5th DIV cycle -> next cycle busy=0, disp_data=0, state OPA; then keys 3,E -> disp_data 3.
